// File: rtl/complex_circuit_pipe_if.sv
// rtl/complex_circuit_pipe_if.sv - valid/ready operand and result bus for complex_circuit_pipe
interface complex_circuit_pipe_if #(parameter int WIDTH = 4);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] e;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_z;

  modport master (
    output in_valid, a, b, c, d, e, out_ready,
    input  in_ready, out_valid, out_z
  );

  modport slave (
    input  in_valid, a, b, c, d, e, out_ready,
    output in_ready, out_valid, out_z
  );
endinterface

// File: rtl/complex_circuit_pipe.sv
// rtl/complex_circuit_pipe.sv - two-stage pipelined gate network z = ~(e&(c^d)) | (((a&b)|c)&~d)
module complex_circuit_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  complex_circuit_pipe_if.slave bus,
  output logic [CNT_W-1:0]     beat_cnt
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_adv;
  logic             s2_adv;

  always_comb begin
    s2_adv     = !s2_valid_q || bus.out_ready;
    s1_adv     = !s1_valid_q || s2_adv;
    s1_valid_d = s1_valid_q;
    p_d        = p_q;
    q_d        = q_q;
    r_d        = r_q;
    s2_valid_d = s2_valid_q;
    z_d        = z_q;
    cnt_d      = cnt_q;

    // Data registers only capture real beats; bubbles leave them untouched.
    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        p_d = (bus.a & bus.b) | bus.c;
        q_d = ~bus.d;
        r_d = ~(bus.e & (bus.c ^ bus.d));
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        z_d = r_q | (p_q & q_q);
      end
    end

    if (s2_valid_q && bus.out_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      p_q        <= '0;
      q_q        <= '0;
      r_q        <= '0;
      s2_valid_q <= 1'b0;
      z_q        <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      p_q        <= p_d;
      q_q        <= q_d;
      r_q        <= r_d;
      s2_valid_q <= s2_valid_d;
      z_q        <= z_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_z     = z_q;
  assign beat_cnt      = cnt_q;

endmodule

// File: tb/tb_complex_circuit_pipe.sv
// tb/tb_complex_circuit_pipe.sv - scoreboard bench for complex_circuit_pipe
module tb_complex_circuit_pipe;
  localparam int W  = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  complex_circuit_pipe_if #(.WIDTH(W)) bus ();
  logic [CW-1:0] beat_cnt;

  complex_circuit_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .beat_cnt (beat_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int model_cnt = 0;
  logic stalled_prev = 1'b0;
  logic [W-1:0] prev_z = '0;

  function automatic logic [W-1:0] ref_z(input logic [W-1:0] a, b, c, d, e);
    return ~(e & (c ^ d)) | (((a & b) | c) & ~d);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: everything is sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stalled_prev) begin
        chk("stall_valid_hold", 32'(bus.out_valid), 32'd1);
        chk("stall_z_hold", 32'(bus.out_z), 32'(prev_z));
      end
      chk("in_ready_model", 32'(bus.in_ready), 32'(!(exp_q.size() == 2 && !bus.out_ready)));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("out_unexpected", 32'd1, 32'd0);
        end else begin
          chk("out_z_order", 32'(bus.out_z), 32'(exp_q.pop_front()));
        end
        chk("beat_cnt_model", 32'(beat_cnt), 32'(model_cnt));
        model_cnt = (model_cnt + 1) % (1 << CW);
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_z(bus.a, bus.b, bus.c, bus.d, bus.e));
      end
      stalled_prev = bus.out_valid && !bus.out_ready;
      prev_z = bus.out_z;
    end
  end

  task automatic send(input logic [W-1:0] va, vb, vc, vd, ve, output int waits);
    bus.in_valid = 1'b1;
    bus.a = va; bus.b = vb; bus.c = vc; bus.d = vd; bus.e = ve;
    waits = 0;
    @(negedge clk);
    while (!bus.in_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!bus.in_ready) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_rand(output int waits);
    send(W'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom), waits);
  endtask

  task automatic expect_lit(input string name, input logic [W-1:0] lit);
    int n = 0;
    @(negedge clk);
    while (!(bus.out_valid && bus.out_ready) && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_seen"}, 32'(bus.out_valid), 32'd1);
    chk(name, 32'(bus.out_z), 32'(lit));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    int total_w;
    int wrap_tbl[5];
    bit done;
    wrap_tbl = '{1, 2, 3, 0, 1};
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0; bus.e = '0;

    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_z", 32'(bus.out_z), 32'd0);
    chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single beat with latency probe.
    send(4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b1111, w);
    @(negedge clk);
    chk("lat_edge1_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("lat_edge2_valid", 32'(bus.out_valid), 32'd1);
    chk("single_z", 32'(bus.out_z), 32'hF);
    @(posedge clk); #1;
    @(negedge clk);
    chk("single_beat_cnt", 32'(beat_cnt), 32'd1);
    @(posedge clk); #1;

    send(4'b1100, 4'b1010, 4'b0001, 4'b0011, 4'b1111, w);
    send(4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b1111, w);
    expect_lit("mixed1_z", 4'b1101);
    expect_lit("mixed2_z", 4'b0000);
    drain();

    total_w = 0;
    for (int i = 0; i < 16; i++) begin
      send_rand(w);
      total_w += w;
    end
    chk("stream_no_stall", 32'(total_w), 32'd0);
    drain();

    fork
      begin
        for (int i = 0; i < 10; i++) send_rand(w);
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          send_rand(w);
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of a stream.
    fork
      begin
        for (int i = 0; i < 4; i++) send_rand(w);
      end
      begin
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_out_z", 32'(bus.out_z), 32'd0);
        chk("midrst_beat_cnt", 32'(beat_cnt), 32'd0);
      end
    join
    bus.in_valid = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    stalled_prev = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_no_output", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      send_rand(w);
      drain();
      @(negedge clk);
      chk($sformatf("wrap_cnt_%0d", i), 32'(beat_cnt), 32'(wrap_tbl[i]));
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
